// File: rtl/tx_queue_feeder_pkg.sv
// rtl/tx_queue_feeder_pkg.sv - shared FSM state type and default settle length for the TX queue feeder
package tx_queue_feeder_pkg;

  localparam int GUARD_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    SETTLE    = 2'd2,
    WAIT_FREE = 2'd3
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser with asynchronous active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tx_queue_feeder.sv
// rtl/tx_queue_feeder.sv - circular word queue that hands one word at a time to a cross-domain adapter
module tx_queue_feeder
  import tx_queue_feeder_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  parameter int GUARD = GUARD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       available,
  output logic                       start_tx,
  output logic [WIDTH-1:0]           dat_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GUARD);

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [GW-1:0]    guard_cnt;
  logic             avail_s;
  logic             push_ok;
  logic             pop;
  logic             issue;

  sync_2ff u_avail_sync (
    .clk (clk),
    .rst (rst),
    .d   (available),
    .q   (avail_s)
  );

  assign full    = (count == CW'(DEPTH));
  assign push_ok = push & ~full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_tx  = 1'b0;
    issue     = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && avail_s) begin
          state_nxt = ISSUE;
          issue     = 1'b1;
        end
      end
      ISSUE: begin
        start_tx  = 1'b1;
        state_nxt = SETTLE;
      end
      // avail_s is ignored here so the pre-issue ready level cannot be mistaken for completion
      SETTLE: begin
        if (guard_cnt == '0) state_nxt = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (avail_s) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_cnt <= '0;
    end else if (state == ISSUE) begin
      guard_cnt <= GW'(GUARD - 1);
    end else if (state == SETTLE && guard_cnt != '0) begin
      guard_cnt <= guard_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dat_out  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      // a dropped push is flagged even when a pop frees an entry on the same edge
      if (push && full) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (issue) dat_out <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_tx_queue_feeder.sv
// tb/tb_tx_queue_feeder.sv - directed self-checking bench for tx_queue_feeder
module tb_tx_queue_feeder;
  import tx_queue_feeder_pkg::*;

  localparam int W = 128;
  localparam int D = 8;

  logic         clk;
  logic         rst;
  logic         push;
  logic [W-1:0] push_dat;
  logic         full;
  logic [3:0]   count;
  logic         overflow;
  logic         available;
  logic         start_tx;
  logic [W-1:0] dat_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] cap[$];

  tx_queue_feeder #(.WIDTH(W), .DEPTH(D), .GUARD(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_dat  (push_dat),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .available (available),
    .start_tx  (start_tx),
    .dat_out   (dat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst === 1'b1 && start_tx === 1'b1) cap.push_back(dat_out);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] word(input int tag, input int i);
    word = {tag[31:0], 64'h0123_4567_89AB_CDEF, i[31:0]};
  endfunction

  task automatic apply_reset();
    push      = 1'b0;
    push_dat  = '0;
    available = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cap.delete();
  endtask

  task automatic fill_queue(input int tag);
    for (int i = 0; i < D; i++) begin
      push = 1'b1;
      push_dat = word(tag, i);
      @(negedge clk);
    end
    push = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; push = 1'b0; push_dat = '0; available = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (count !== 4'd0)   begin n_fail++; $display("FAIL reset_count: got %0d required 0", count); end
    n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full: got %0b required 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b required 0", overflow); end
    n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL reset_start_tx: got %0b required 0", start_tx); end
    n_checks++; if (dat_out !== '0)   begin n_fail++; $display("FAIL reset_dat_out: got %0h required 0", dat_out); end
    rst = 1'b1;
    cap.delete();
  endtask

  task automatic test_single();
    apply_reset();
    available = 1'b1;
    repeat (3) @(negedge clk);
    push = 1'b1; push_dat = 128'hA5;
    @(negedge clk);
    push = 1'b0;
    n_checks++; if (count !== 4'd1)    begin n_fail++; $display("FAIL single_count_after_push: got %0d required 1", count); end
    n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL single_early_start: got %0b required 0", start_tx); end
    @(negedge clk);
    n_checks++; if (start_tx !== 1'b1) begin n_fail++; $display("FAIL single_latency_start: got %0b required 1", start_tx); end
    n_checks++; if (dat_out !== 128'hA5) begin n_fail++; $display("FAIL single_dat_out: got %0h required a5", dat_out); end
    @(negedge clk);
    n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %0b required 0", start_tx); end
    n_checks++; if (dat_out !== 128'hA5) begin n_fail++; $display("FAIL single_dat_hold: got %0h required a5", dat_out); end
    repeat (3) @(negedge clk);
    n_checks++; if (count !== 4'd1)    begin n_fail++; $display("FAIL single_no_early_pop: got %0d required 1", count); end
    @(negedge clk);
    n_checks++; if (count !== 4'd0)    begin n_fail++; $display("FAIL single_popped: got %0d required 0", count); end
    repeat (10) @(negedge clk);
    n_checks++; if (cap.size() !== 1)  begin n_fail++; $display("FAIL single_pulse_count: got %0d required 1", cap.size()); end
  endtask

  task automatic test_overflow();
    apply_reset();
    repeat (3) @(negedge clk);
    fill_queue(32'h0F);
    n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full: got %0b required 1", full); end
    n_checks++; if (count !== 4'd8)    begin n_fail++; $display("FAIL ovf_count8: got %0d required 8", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %0b required 0", overflow); end
    push = 1'b1; push_dat = 128'hEE;
    @(negedge clk);
    push = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b required 1", overflow); end
    n_checks++; if (count !== 4'd8)    begin n_fail++; $display("FAIL ovf_count_hold: got %0d required 8", count); end
    repeat (10) @(negedge clk);
    n_checks++; if (cap.size() !== 0)  begin n_fail++; $display("FAIL ovf_no_start: got %0d pulses required 0", cap.size()); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b required 1", overflow); end
  endtask

  task automatic test_full_pop_push();
    int k;
    apply_reset();
    repeat (3) @(negedge clk);
    fill_queue(32'hF0);
    available = 1'b1;
    repeat (7) @(negedge clk);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_before_pop: got %0d required 8", count); end
    push = 1'b1; push_dat = 128'hEE;
    @(negedge clk);
    push = 1'b0;
    n_checks++; if (count !== 4'd7)    begin n_fail++; $display("FAIL fpp_count7: got %0d required 7", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_overflow: got %0b required 1", overflow); end
    k = 0;
    while ((count !== 4'd0 || dut.state !== IDLE) && k < 300) begin @(negedge clk); k++; end
    n_checks++; if (k >= 300) begin n_fail++; $display("FAIL fpp_drain_timeout: count=%0d required 0", count); end
    n_checks++; if (cap.size() !== D) begin n_fail++; $display("FAIL fpp_words: got %0d required %0d", cap.size(), D); end
    for (int i = 0; i < D && i < cap.size(); i++) begin
      n_checks++;
      if (cap[i] !== word(32'hF0, i)) begin n_fail++; $display("FAIL fpp_order[%0d]: got %0h required %0h", i, cap[i], word(32'hF0, i)); end
    end
  endtask

  task automatic test_three_toggle();
    int k;
    apply_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_dat = word(32'h33, i);
      @(negedge clk);
    end
    push = 1'b0;
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL three_count: got %0d required 3", count); end
    for (int i = 0; i < 3; i++) begin
      available = 1'b1;
      k = 0;
      while (start_tx !== 1'b1 && k < 30) begin @(negedge clk); k++; end
      n_checks++; if (k >= 30) begin n_fail++; $display("FAIL three_start_timeout[%0d]: start_tx=%0b required 1", i, start_tx); end
      available = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++; if (count !== 4'(3 - i)) begin n_fail++; $display("FAIL three_held[%0d]: got %0d required %0d", i, count, 3 - i); end
      n_checks++;
      if (cap.size() !== i + 1 || cap[i] !== word(32'h33, i)) begin
        n_fail++; $display("FAIL three_word[%0d]: got %0h (n=%0d) required %0h", i, dat_out, cap.size(), word(32'h33, i));
      end
    end
    available = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (count !== 4'd0)   begin n_fail++; $display("FAIL three_drained: got %0d required 0", count); end
    n_checks++; if (cap.size() !== 3) begin n_fail++; $display("FAIL three_pulses: got %0d required 3", cap.size()); end
  endtask

  task automatic test_reset_mid();
    int k;
    int n0;
    apply_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_dat = word(32'h44, i);
      @(negedge clk);
    end
    push = 1'b0;
    available = 1'b1;
    k = 0;
    while (start_tx !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    n_checks++; if (k >= 30) begin n_fail++; $display("FAIL mid_start_timeout: start_tx=%0b required 1", start_tx); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0)    begin n_fail++; $display("FAIL mid_count: got %0d required 0", count); end
    n_checks++; if (start_tx !== 1'b0) begin n_fail++; $display("FAIL mid_start_tx: got %0b required 0", start_tx); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL mid_state: got %0d required IDLE", dut.state); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n0 = cap.size();
    repeat (30) @(negedge clk);
    n_checks++; if (cap.size() !== n0) begin n_fail++; $display("FAIL mid_no_restart: got %0d pulses required %0d", cap.size(), n0); end
  endtask

  task automatic test_back_to_back();
    int k;
    apply_reset();
    available = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_dat = word(32'hB2B, i);
      @(negedge clk);
    end
    push = 1'b0;
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL b2b_count4: got %0d required 4", count); end
    for (int i = 4; i < 15; i++) begin
      k = 0;
      while (dut.state !== WAIT_FREE && k < 30) begin @(negedge clk); k++; end
      if (k >= 30) begin
        n_checks++; n_fail++; $display("FAIL b2b_wait_timeout[%0d]: state=%0d required WAIT_FREE", i, dut.state);
      end
      push = 1'b1; push_dat = word(32'hB2B, i);
      @(negedge clk);
      push = 1'b0;
      n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL b2b_count_steady[%0d]: got %0d required 4", i, count); end
    end
    k = 0;
    while ((count !== 4'd0 || dut.state !== IDLE) && k < 200) begin @(negedge clk); k++; end
    n_checks++; if (k >= 200) begin n_fail++; $display("FAIL b2b_drain_timeout: count=%0d required 0", count); end
    n_checks++; if (cap.size() !== 15) begin n_fail++; $display("FAIL b2b_words: got %0d required 15", cap.size()); end
    for (int i = 0; i < 15 && i < cap.size(); i++) begin
      n_checks++;
      if (cap[i] !== word(32'hB2B, i)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0h required %0h", i, cap[i], word(32'hB2B, i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop_push();
    test_three_toggle();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_queue_feeder.md
TX_QUEUE_FEEDER -- requirements
Module: tx_queue_feeder

Interface
REQ-001 Parameter WIDTH, default 128, data word width in bits.
REQ-002 Parameter DEPTH, default 8, queue entries; SHALL be a power of two, 2 or more.
REQ-003 Parameter GUARD, default 3, post-issue settle cycles; SHALL be at least 3.
REQ-004 clk  input  1  sole clock; the block SHALL use one clock; all state on rising edge.
REQ-005 rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-006 push  input  1  producer write strobe, sampled each cycle.
REQ-007 push_dat  input  WIDTH  producer data, valid with push.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-010 overflow  output  1  sticky flag: a push was dropped.
REQ-011 available  input  1  downstream adapter ready flag, from another clock domain, unsynchronised.
REQ-012 start_tx  output  1  one-cycle request to the downstream adapter.
REQ-013 dat_out  output  WIDTH  word offered to the adapter; valid while start_tx is high.

Function
REQ-014 available SHALL pass through a 2-flop synchroniser; the FSM SHALL use only the synchronised value (avail_s).
REQ-015 Queue SHALL be a circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-016 push while not full SHALL store push_dat at the write pointer and increment count on that edge.
REQ-017 push while full SHALL drop the word and set overflow; this SHALL hold even if a pop occurs in the same cycle.
REQ-018 FSM states SHALL be IDLE, ISSUE, SETTLE and WAIT_FREE.
REQ-019 IDLE -> ISSUE when count != 0 and avail_s == 1; the head word SHALL be registered into dat_out on that edge.
REQ-020 In ISSUE, start_tx SHALL be high for exactly one cycle, and dat_out SHALL be stable; next state SHALL be SETTLE.
REQ-021 SETTLE SHALL last GUARD cycles, counted down with avail_s ignored, to flush stale synchroniser contents; then WAIT_FREE.
REQ-022 WAIT_FREE -> IDLE when avail_s == 1; on that edge the head SHALL be popped (read pointer +1, count -1).
REQ-023 Simultaneous push (not full) and pop SHALL leave count unchanged and update both pointers.
REQ-024 start_tx SHALL be low in every state except ISSUE.
REQ-025 dat_out SHALL hold its last value outside ISSUE.
REQ-026 Latency: with an empty queue in IDLE and avail_s == 1, a push at edge N SHALL give start_tx high in the cycle after edge N+1.
REQ-027 A word SHALL never be issued twice, and SHALL never be popped before WAIT_FREE completes.
REQ-028 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-029 While rst is low: pointers, count, overflow, start_tx and synchroniser flops SHALL be 0, dat_out SHALL be 0, and state SHALL be IDLE.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction and discard all queued words.
REQ-031 overflow SHALL clear only on reset.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the default GUARD constant.
REQ-033 The synchroniser SHALL be a separate sub-module, sync_2ff (1-bit, asynchronous active-low reset).
REQ-034 Storage SHALL be a register array with no output bypass from push_dat to dat_out.

Verification
REQ-035 Hold available=1 and push 0xA5 once -> start_tx pulses one cycle with dat_out=0xA5, count returns to 0 after WAIT_FREE.
REQ-036 Hold available=0 and push 8 words -> full=1 and count=8; a 9th push sets overflow=1 and count stays 8, with no start_tx.
REQ-037 Queue 3 words, then toggle available low/high per transfer -> start_tx pulses exactly 3 times with words in push order.
REQ-038 Queue full, pop coinciding with a push -> push dropped, overflow=1, count=7.
REQ-039 Assert rst during SETTLE with 4 queued -> count=0, start_tx=0, state IDLE, and no further start_tx after release.
REQ-040 Push and pop in the same cycle at count=4 -> count stays 4 and pointer wrap-around passes 15 consecutive words correctly.
